pzcorebus_gate_controller: RTL and testbench
============================================

PZCOREBUS_GATE_CONTROLLER -- requirements
Module: pzcorebus_gate_controller

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 64: maximum tracked non-posted commands awaiting response.
REQ-002 Parameter INITIAL_ENABLE, default 1: enable state entered on reset.
REQ-003 Derived COUNT_WIDTH = $clog2(MAX_OUTSTANDING+1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  clock.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_disable_request  input  1  level: 1 requests gate disabled, 0 requests gate enabled.
REQ-008 i_command_valid / i_command_accept  input  1 each  bus command handshake, monitored.
REQ-009 i_command_non_posted  input  1  command expects a response.
REQ-010 i_command_with_data  input  1  command carries a write-data burst.
REQ-011 i_write_data_valid / i_write_data_accept / i_write_data_last  input  1 each  write-data handshake, monitored.
REQ-012 i_response_valid / i_response_accept / i_response_last  input  1 each  response handshake, monitored.
REQ-013 o_enable  output  1  drives the gate enable; 1 = pass to master, 0 = route to dummy slave.
REQ-014 o_command_block  output  1  upstream must not raise a new command valid while 1.
REQ-015 o_disabled  output  1  status: gate fully disabled.
REQ-016 o_busy  output  1  transition in progress (STOPPING, DRAINING or RESUMING).
REQ-017 o_outstanding  output  COUNT_WIDTH  current outstanding non-posted count.
REQ-018 o_error  output  1  sticky counter overflow/underflow flag.

Function
REQ-019 States ENABLED, STOPPING, DRAINING, DISABLED, RESUMING; all outputs registered.
REQ-020 ENABLED -> STOPPING when i_disable_request=1; o_command_block rises the cycle after the request is sampled.
REQ-021 STOPPING -> DRAINING once no command is pending (i_command_valid=0, or accepted this cycle) and write-data pending count is 0.
REQ-022 DRAINING -> DISABLED when o_outstanding=0 and no response handshake is in progress mid-burst.
REQ-023 DISABLED -> RESUMING when i_disable_request=0; RESUMING -> ENABLED after exactly one cycle.
REQ-024 STOPPING or DRAINING with i_disable_request deasserted: complete to DISABLED, then resume; no transition is aborted.
REQ-025 o_enable=1 in ENABLED, STOPPING, DRAINING; 0 in DISABLED; 1 in RESUMING.
REQ-026 o_command_block=1 in STOPPING, DRAINING, DISABLED, RESUMING; 0 in ENABLED.
REQ-027 o_disabled=1 only in DISABLED.
REQ-028 Outstanding counter: +1 on command handshake with non_posted=1; -1 on response handshake with last=1; both in one cycle: unchanged.
REQ-029 Increment at MAX_OUTSTANDING: counter saturates, o_error set.
REQ-030 Decrement at 0: counter holds 0, o_error set.
REQ-031 Write-data pending counter, same width: +1 on command handshake with with_data=1; -1 on write-data handshake with last=1; same saturation/error rules.
REQ-032 Counters track in every state, including DISABLED.
REQ-033 o_error clears only on reset.

Reset
REQ-034 Reset: state = ENABLED if INITIAL_ENABLE=1, else DISABLED; counters 0; o_error 0.
REQ-035 Outputs during/after reset follow REQ-025..027 for the reset state; o_busy 0.
REQ-036 Reset mid-transition returns to the reset state in one cycle; in-flight counts are discarded.

Verification
REQ-037 Idle bus, i_disable_request 0->1 -> STOPPING, DRAINING, DISABLED on consecutive cycles; o_enable falls 3 cycles after request sampled.
REQ-038 3 non-posted commands accepted, disable request, responses returned 5 cycles apart -> o_enable stays 1 until cycle after third last response; o_outstanding 3->0.
REQ-039 Command valid held unaccepted 4 cycles when disable requested -> remains in STOPPING until accept; o_command_block=1 throughout.
REQ-040 Command accept (non-posted) and response last in same cycle with count 2 -> count stays 2.
REQ-041 Response last with count 0 -> o_error=1, count 0; MAX_OUTSTANDING+1 commands -> count saturates, o_error=1.
REQ-042 Reset asserted during DRAINING with count 5 -> next cycle ENABLED, count 0, o_enable=1, o_command_block=0.

Source files
------------

// File: rtl/pzcorebus_gate_controller_if.sv
// Gate-controller signal bundle: disable request, monitored handshakes and gate status.
interface pzcorebus_gate_controller_if #(
  parameter int MAX_OUTSTANDING = 64
);
  localparam int COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic                   disable_request;
  logic                   command_valid;
  logic                   command_accept;
  logic                   command_non_posted;
  logic                   command_with_data;
  logic                   write_data_valid;
  logic                   write_data_accept;
  logic                   write_data_last;
  logic                   response_valid;
  logic                   response_accept;
  logic                   response_last;
  logic                   enable;
  logic                   command_block;
  logic                   disabled;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] outstanding;
  logic                   error;

  // Controller side: observes the bus, drives gate control and status.
  modport master (
    input  disable_request, command_valid, command_accept, command_non_posted,
           command_with_data, write_data_valid, write_data_accept, write_data_last,
           response_valid, response_accept, response_last,
    output enable, command_block, disabled, busy, outstanding, error
  );

  // System side: raises requests and bus activity, consumes gate control.
  modport slave (
    output disable_request, command_valid, command_accept, command_non_posted,
           command_with_data, write_data_valid, write_data_accept, write_data_last,
           response_valid, response_accept, response_last,
    input  enable, command_block, disabled, busy, outstanding, error
  );
endinterface

// File: rtl/pzcorebus_gate_controller.sv
// Gate controller: quiesces a bus port (block commands, drain write data and
// responses) before switching the gate to the dummy slave, and resumes on request.
module pzcorebus_gate_controller #(
  parameter int MAX_OUTSTANDING = 64,
  parameter bit INITIAL_ENABLE  = 1'b1
)(
  input logic                         i_clk,
  input logic                         i_rst,
  pzcorebus_gate_controller_if.master bus
);
  localparam int COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    ENABLED,
    STOPPING,
    DRAINING,
    DISABLED,
    RESUMING
  } state_t;

  localparam state_t RESET_STATE = INITIAL_ENABLE ? ENABLED : DISABLED;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] outstanding_q;
  logic [COUNT_WIDTH-1:0] write_pending_q;
  logic                   response_in_burst;
  logic                   error_q;
  logic                   enable_q;
  logic                   command_block_q;
  logic                   disabled_q;
  logic                   busy_q;

  logic command_hs;
  logic write_data_hs;
  logic response_hs;
  logic command_idle;
  logic write_data_idle;
  logic [COUNT_WIDTH:0] outstanding_upd;
  logic [COUNT_WIDTH:0] write_pending_upd;

  // Returns {overflow_or_underflow, next_count}; simultaneous inc/dec cancel.
  function automatic logic [COUNT_WIDTH:0] count_update(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic                   inc,
    input logic                   dec
  );
    count_update = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == COUNT_MAX) count_update[COUNT_WIDTH] = 1'b1;
      else                  count_update[COUNT_WIDTH-1:0] = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) count_update[COUNT_WIDTH] = 1'b1;
      else           count_update[COUNT_WIDTH-1:0] = cnt - 1'b1;
    end
  endfunction

  assign command_hs    = bus.command_valid && bus.command_accept;
  assign write_data_hs = bus.write_data_valid && bus.write_data_accept;
  assign response_hs   = bus.response_valid && bus.response_accept;

  assign command_idle    = !bus.command_valid || bus.command_accept;
  // A data-carrying command accepted in this cycle still owes its burst.
  assign write_data_idle = (write_pending_q == '0) && !(command_hs && bus.command_with_data);

  assign outstanding_upd   = count_update(outstanding_q,
                                          command_hs && bus.command_non_posted,
                                          response_hs && bus.response_last);
  assign write_pending_upd = count_update(write_pending_q,
                                          command_hs && bus.command_with_data,
                                          write_data_hs && bus.write_data_last);

  always_comb begin
    state_next = state;
    case (state)
      ENABLED:  if (bus.disable_request) state_next = STOPPING;
      STOPPING: if (command_idle && write_data_idle) state_next = DRAINING;
      DRAINING: if ((outstanding_q == '0) && !response_in_burst) state_next = DISABLED;
      DISABLED: if (!bus.disable_request) state_next = RESUMING;
      RESUMING: state_next = ENABLED;
      default:  state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RESET_STATE;
    else       state <= state_next;
  end

  // Status outputs are decoded from the next state so they are registered yet
  // line up cycle-for-cycle with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      outstanding_q     <= '0;
      write_pending_q   <= '0;
      response_in_burst <= 1'b0;
      error_q           <= 1'b0;
      enable_q          <= INITIAL_ENABLE;
      command_block_q   <= !INITIAL_ENABLE;
      disabled_q        <= !INITIAL_ENABLE;
      busy_q            <= 1'b0;
    end else begin
      outstanding_q   <= outstanding_upd[COUNT_WIDTH-1:0];
      write_pending_q <= write_pending_upd[COUNT_WIDTH-1:0];
      error_q         <= error_q || outstanding_upd[COUNT_WIDTH] || write_pending_upd[COUNT_WIDTH];
      if (response_hs) response_in_burst <= !bus.response_last;
      enable_q        <= (state_next != DISABLED);
      command_block_q <= (state_next != ENABLED);
      disabled_q      <= (state_next == DISABLED);
      busy_q          <= (state_next == STOPPING) || (state_next == DRAINING) ||
                         (state_next == RESUMING);
    end
  end

  assign bus.enable        = enable_q;
  assign bus.command_block = command_block_q;
  assign bus.disabled      = disabled_q;
  assign bus.busy          = busy_q;
  assign bus.outstanding   = outstanding_q;
  assign bus.error         = error_q;
endmodule

// File: tb/tb_pzcorebus_gate_controller.sv
// Directed and randomized checks of the gate controller against a phase-level reference model.
module tb_pzcorebus_gate_controller;
  localparam int MAX = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pzcorebus_gate_controller_if #(.MAX_OUTSTANDING(MAX)) bus ();

  pzcorebus_gate_controller #(
    .MAX_OUTSTANDING(MAX),
    .INITIAL_ENABLE (1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  string m_phase = "ENABLED";
  int    m_out   = 0;
  int    m_wd    = 0;
  bit    m_err   = 1'b0;
  bit    m_burst = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.command_valid      = 1'b0;
    bus.command_accept     = 1'b0;
    bus.command_non_posted = 1'b0;
    bus.command_with_data  = 1'b0;
    bus.write_data_valid   = 1'b0;
    bus.write_data_accept  = 1'b0;
    bus.write_data_last    = 1'b0;
    bus.response_valid     = 1'b0;
    bus.response_accept    = 1'b0;
    bus.response_last      = 1'b0;
  endtask

  // Apply one clock of the rules to the model using the inputs in front of the edge.
  task automatic model_edge();
    bit    cmd  = bus.command_valid && bus.command_accept;
    bit    wdh  = bus.write_data_valid && bus.write_data_accept;
    bit    rsp  = bus.response_valid && bus.response_accept;
    int    dout = int'(cmd && bus.command_non_posted) - int'(rsp && bus.response_last);
    int    dwd  = int'(cmd && bus.command_with_data) - int'(wdh && bus.write_data_last);
    string nxt  = m_phase;
    if (rst) begin
      m_phase = "ENABLED"; m_out = 0; m_wd = 0; m_err = 1'b0; m_burst = 1'b0;
      return;
    end
    if (m_phase == "ENABLED") begin
      if (bus.disable_request) nxt = "STOPPING";
    end else if (m_phase == "STOPPING") begin
      if ((!bus.command_valid || bus.command_accept) && m_wd == 0 &&
          !(cmd && bus.command_with_data)) nxt = "DRAINING";
    end else if (m_phase == "DRAINING") begin
      if (m_out == 0 && !m_burst) nxt = "DISABLED";
    end else if (m_phase == "DISABLED") begin
      if (!bus.disable_request) nxt = "RESUMING";
    end else begin
      nxt = "ENABLED";
    end
    m_phase = nxt;
    m_out += dout;
    if (m_out > MAX) begin m_out = MAX; m_err = 1'b1; end
    if (m_out < 0)   begin m_out = 0;   m_err = 1'b1; end
    m_wd += dwd;
    if (m_wd > MAX) begin m_wd = MAX; m_err = 1'b1; end
    if (m_wd < 0)   begin m_wd = 0;   m_err = 1'b1; end
    if (rsp) m_burst = !bus.response_last;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("enable",        bus.enable,        m_phase != "DISABLED");
    check("command_block", bus.command_block, m_phase != "ENABLED");
    check("disabled",      bus.disabled,      m_phase == "DISABLED");
    check("busy",          bus.busy,          m_phase == "STOPPING" || m_phase == "DRAINING" ||
                                              m_phase == "RESUMING");
    check("outstanding",   bus.outstanding,   m_out);
    check("error",         bus.error,         m_err);
  endtask

  task automatic np_command();
    bus.command_valid = 1'b1; bus.command_accept = 1'b1; bus.command_non_posted = 1'b1;
    step();
    idle();
  endtask

  task automatic last_response();
    bus.response_valid = 1'b1; bus.response_accept = 1'b1; bus.response_last = 1'b1;
    step();
    idle();
  endtask

  initial begin
    idle();
    bus.disable_request = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_enable", bus.enable, 1);
    check("reset_block",  bus.command_block, 0);
    check("reset_busy",   bus.busy, 0);

    // Idle-bus disable: STOPPING, DRAINING, DISABLED on consecutive edges.
    bus.disable_request = 1'b1;
    step(); check("idle_stop_block", bus.command_block, 1);
    step(); check("idle_drain_enable", bus.enable, 1);
    step(); check("idle_disabled_enable", bus.enable, 0);
    check("idle_disabled_flag", bus.disabled, 1);
    bus.disable_request = 1'b0;
    step(); check("resume_busy", bus.busy, 1);
    step(); check("resumed_block", bus.command_block, 0);

    // Three outstanding reads drained by responses five cycles apart.
    repeat (3) np_command();
    check("three_outstanding", bus.outstanding, 3);
    bus.disable_request = 1'b1;
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      last_response();
      check("drain_enable_held", bus.enable, 1);
      if (k < 2) repeat (4) step();
    end
    check("drained_count", bus.outstanding, 0);
    step(); check("drain_enable_fall", bus.enable, 0);
    bus.disable_request = 1'b0;
    step(); step();

    // Command held unaccepted while stopping.
    bus.command_valid = 1'b1;
    bus.disable_request = 1'b1;
    step();
    repeat (4) begin
      step();
      check("stall_block", bus.command_block, 1);
      check("stall_enable", bus.enable, 1);
    end
    bus.command_accept = 1'b1;
    step(); idle();
    step(); check("stall_disabled", bus.disabled, 1);
    bus.disable_request = 1'b0;
    step(); step();

    // Simultaneous increment and decrement.
    np_command(); np_command();
    bus.command_valid = 1'b1; bus.command_accept = 1'b1; bus.command_non_posted = 1'b1;
    bus.response_valid = 1'b1; bus.response_accept = 1'b1; bus.response_last = 1'b1;
    step(); idle();
    check("simul_count", bus.outstanding, 2);
    last_response(); last_response();

    // Underflow and overflow.
    last_response();
    check("underflow_error", bus.error, 1);
    check("underflow_count", bus.outstanding, 0);
    rst = 1'b1; step(); rst = 1'b0;
    check("error_cleared", bus.error, 0);
    repeat (MAX + 1) np_command();
    check("overflow_count", bus.outstanding, MAX);
    check("overflow_error", bus.error, 1);
    rst = 1'b1; step(); rst = 1'b0;

    // Reset while draining with five outstanding.
    repeat (5) np_command();
    bus.disable_request = 1'b1;
    step(); step(); step();
    check("drain_busy", bus.busy, 1);
    rst = 1'b1; bus.disable_request = 1'b0;
    step();
    rst = 1'b0;
    check("mid_reset_enable", bus.enable, 1);
    check("mid_reset_block", bus.command_block, 0);
    check("mid_reset_count", bus.outstanding, 0);

    // Randomized traffic with occasional disable toggles and resets.
    for (int i = 0; i < 600; i++) begin
      bus.command_valid      = ($urandom_range(0, 2) == 0);
      bus.command_accept     = $urandom_range(0, 1) == 1;
      bus.command_non_posted = $urandom_range(0, 1) == 1;
      bus.command_with_data  = $urandom_range(0, 1) == 1;
      bus.write_data_valid   = $urandom_range(0, 1) == 1;
      bus.write_data_accept  = $urandom_range(0, 1) == 1;
      bus.write_data_last    = $urandom_range(0, 1) == 1;
      bus.response_valid     = $urandom_range(0, 1) == 1;
      bus.response_accept    = $urandom_range(0, 1) == 1;
      bus.response_last      = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 19) == 0) bus.disable_request = !bus.disable_request;
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
